// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the hazard controller's pipeline-side signals into one bundle.
//   master : the pipeline. It drives the hazard sources (IF/ID source regs,
//            ID/EX load info, branch resolution, MEM handshake) and receives
//            the stall/flush/freeze controls and the status/perf outputs.
//   slave  : the hazard controller. It receives the sources and drives the
//            controls.
// Parameter CNT_W : width of each performance counter.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             ifid_uses_rs2;
  logic             idex_Mem_Read;
  logic [4:0]       idex_rd;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_stall;
  logic             pipe_freeze;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] load_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_Mem_Read, idex_rd,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_stall, pipe_freeze,
           state, mem_timeout, load_stall_cnt, flush_cnt, mem_wait_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_Mem_Read, idex_rd,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_stall, pipe_freeze,
           state, mem_timeout, load_stall_cnt, flush_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a 5-stage in-order pipeline. Resolves, in priority
// order, a MEM-stage wait (freeze the whole pipe), a taken branch (flush
// IF/ID and bubble ID/EX) and a load-use hazard (hold PC/IF/ID and bubble
// ID/EX). Control outputs are combinational from the FSM state and the
// current inputs; state, wait counter, timeout flag and counters are
// registered.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   hz     : pipe_hazard_ctrl_if.slave (hazard sources in, controls out,
//            state, mem_timeout, load_stall_cnt/flush_cnt/mem_wait_cnt)
// Parameters:
//   MAX_WAIT : wait cycles (2..255) after which mem_timeout latches
//   CNT_W    : performance counter width
// Configuration:
//   HAZARD_PERF_CNT_EN : when defined, the three saturating performance
//                        counters are built; otherwise they read as zero.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;

  logic lu;
  logic mem_stall;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_stall_c, pipe_freeze_c;

  assign lu = hz.idex_Mem_Read && (hz.idex_rd != 5'd0) &&
              ((hz.idex_rd == hz.ifid_rs1) ||
               (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));

  assign mem_stall = hz.dmem_req && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    pipe_freeze_c = 1'b0;
    // While reset is high the inputs are masked and the RUN defaults stand.
    if (!reset) begin
      unique case (state_q)
        MEM_WAIT: begin
          if (!hz.dmem_ready) begin
            pipe_freeze_c = 1'b1;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            wait_d        = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
          end else begin
            // Freeze released this cycle: branch/load-use resolve as in RUN.
            wait_d  = 8'd0;
            state_d = RUN;
            if (hz.branch_taken) begin
              ifid_flush_c = 1'b1;
              idex_stall_c = 1'b1;
              state_d      = FLUSH;
            end else if (lu) begin
              pc_write_c   = 1'b0;
              ifid_write_c = 1'b0;
              idex_stall_c = 1'b1;
            end
          end
        end
        default: begin
          // RUN and FLUSH share the freeze rule; FLUSH ignores branch and lu
          // because IF/ID holds the bubble inserted on the previous edge.
          wait_d  = 8'd0;
          state_d = RUN;
          if (mem_stall) begin
            pipe_freeze_c = 1'b1;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            wait_d        = 8'd1;
            state_d       = MEM_WAIT;
          end else if (state_q == RUN && hz.branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_stall_c = 1'b1;
            state_d      = FLUSH;
          end else if (state_q == RUN && lu) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_stall_c = 1'b1;
          end
        end
      endcase
      if (pipe_freeze_c && (wait_d >= MAX_WAIT_C)) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign hz.pc_write    = pc_write_c;
  assign hz.ifid_write  = ifid_write_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_stall  = idex_stall_c;
  assign hz.pipe_freeze = pipe_freeze_c;
  assign hz.state       = state_q;
  assign hz.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] ls_cnt_q, fl_cnt_q, mw_cnt_q;

  // A bubble without a flush is a load-use stall; a flush always carries one.
  always_ff @(posedge clk) begin
    if (reset) begin
      ls_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      if (idex_stall_c && !ifid_flush_c) ls_cnt_q <= sat_inc(ls_cnt_q);
      if (ifid_flush_c)                  fl_cnt_q <= sat_inc(fl_cnt_q);
      if (pipe_freeze_c)                 mw_cnt_q <= sat_inc(mw_cnt_q);
    end
  end

  assign hz.load_stall_cnt = ls_cnt_q;
  assign hz.flush_cnt      = fl_cnt_q;
  assign hz.mem_wait_cnt   = mw_cnt_q;
`else
  assign hz.load_stall_cnt = '0;
  assign hz.flush_cnt      = '0;
  assign hz.mem_wait_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed vectors for pipe_hazard_ctrl (MAX_WAIT=4). Each step drives one
// cycle of inputs just after the rising edge and queues the hand-computed
// response; a monitor on the falling edge pops and compares. Counter
// expectations are written for HAZARD_PERF_CNT_EN and read as zero otherwise.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  typedef struct {
    int         idx;
    logic       pw, iw, fl, st, fz, to;
    logic [1:0] s;
    int         ls, fc, mw;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  function automatic int ce(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input int idx, input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL vec%0d %s: got=%0d want=%0d", idx, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.idx, "pc_write",       longint'(hz.pc_write),       longint'(mon_e.pw));
      chk(mon_e.idx, "ifid_write",     longint'(hz.ifid_write),     longint'(mon_e.iw));
      chk(mon_e.idx, "ifid_flush",     longint'(hz.ifid_flush),     longint'(mon_e.fl));
      chk(mon_e.idx, "idex_stall",     longint'(hz.idex_stall),     longint'(mon_e.st));
      chk(mon_e.idx, "pipe_freeze",    longint'(hz.pipe_freeze),    longint'(mon_e.fz));
      chk(mon_e.idx, "state",          longint'(hz.state),          longint'(mon_e.s));
      chk(mon_e.idx, "mem_timeout",    longint'(hz.mem_timeout),    longint'(mon_e.to));
      chk(mon_e.idx, "load_stall_cnt", longint'(hz.load_stall_cnt), longint'(ce(mon_e.ls)));
      chk(mon_e.idx, "flush_cnt",      longint'(hz.flush_cnt),      longint'(ce(mon_e.fc)));
      chk(mon_e.idx, "mem_wait_cnt",   longint'(hz.mem_wait_cnt),   longint'(ce(mon_e.mw)));
    end
  end

  // Inputs: rst rs1 rs2 use2 mr rd br req rdy | expected: pw iw fl st fz state to ls fc mw
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic mr, input logic [4:0] rd,
                      input logic br, input logic req, input logic rdy,
                      input logic pw, input logic iw, input logic fl, input logic st,
                      input logic fz, input logic [1:0] s, input logic to,
                      input int ls, input int fc, input int mw);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    hz.ifid_rs1      = rs1;
    hz.ifid_rs2      = rs2;
    hz.ifid_uses_rs2 = u2;
    hz.idex_Mem_Read = mr;
    hz.idex_rd       = rd;
    hz.branch_taken  = br;
    hz.dmem_req      = req;
    hz.dmem_ready    = rdy;
    vec++;
    e.idx = vec; e.pw = pw; e.iw = iw; e.fl = fl; e.st = st; e.fz = fz;
    e.s = s; e.to = to; e.ls = ls; e.fc = fc; e.mw = mw;
    exp_q.push_back(e);
  endtask

  initial begin
    hz.ifid_rs1 = 5'd0; hz.ifid_rs2 = 5'd0; hz.ifid_uses_rs2 = 1'b0;
    hz.idex_Mem_Read = 1'b0; hz.idex_rd = 5'd0; hz.branch_taken = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    // reset held: all hazard sources active but masked
    step(1, 5,0,0,1,5, 1,1,0,  1,1,0,0,0, 2'd0,0, 0,0,0);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 0,0,0);
    // load-use on rs1
    step(0, 5,0,0,1,5, 0,0,0,  0,0,0,1,0, 2'd0,0, 0,0,0);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 1,0,0);
    // rd=0 never hazards; rs2 match ignored unless used
    step(0, 0,0,0,1,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 1,0,0);
    step(0, 3,7,0,1,7, 0,0,0,  1,1,0,0,0, 2'd0,0, 1,0,0);
    step(0, 3,7,1,1,7, 0,0,0,  0,0,0,1,0, 2'd0,0, 1,0,0);
    // branch beats load-use, then one FLUSH cycle ignoring both
    step(0, 5,0,0,1,5, 1,0,0,  1,1,1,1,0, 2'd0,0, 2,0,0);
    step(0, 5,0,0,1,5, 1,0,0,  1,1,0,0,0, 2'd2,0, 2,1,0);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 2,1,0);
    // three freeze cycles (branch ignored while waiting), release with branch
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd0,0, 2,1,0);
    step(0, 0,0,0,0,0, 1,1,0,  0,0,0,0,1, 2'd1,0, 2,1,1);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,0, 2,1,2);
    step(0, 0,0,0,0,0, 1,1,1,  1,1,1,1,0, 2'd1,0, 2,1,3);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd2,0, 2,2,3);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 2,2,3);
    // timeout after the 4th wait cycle, sticky
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd0,0, 2,2,3);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,0, 2,2,4);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,0, 2,2,5);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,0, 2,2,6);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,1, 2,2,7);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd1,1, 2,2,8);
    // reset mid-wait: outputs masked now, state cleared at the edge
    step(1, 0,0,0,0,0, 0,1,0,  1,1,0,0,0, 2'd1,1, 2,2,9);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 0,0,0);
    // freeze inside FLUSH, then release with a load-use hazard
    step(0, 0,0,0,0,0, 1,0,0,  1,1,1,1,0, 2'd0,0, 0,0,0);
    step(0, 0,0,0,0,0, 0,1,0,  0,0,0,0,1, 2'd2,0, 0,1,0);
    step(0, 5,0,0,1,5, 0,1,1,  0,0,0,1,0, 2'd1,0, 0,1,1);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 1,1,1);
    step(0, 0,0,0,0,0, 0,0,0,  1,1,0,0,0, 2'd0,0, 1,1,1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16: number of MEM_WAIT cycles without dmem_ready before mem_timeout asserts (range 2..255).
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ifid_rs1, ifid_rs2  input  5 each  source register indices of the instruction in IF/ID.
REQ-006 ifid_uses_rs2  input  1  IF/ID instruction reads rs2.
REQ-007 idex_Mem_Read  input  1  the instruction in ID/EX is a load.
REQ-008 idex_rd  input  5  destination register of the instruction in ID/EX.
REQ-009 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-010 dmem_req, dmem_ready  input  1 each  MEM-stage access present / access completes this cycle.
REQ-011 pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-012 ifid_flush  output  1  zero IF/ID next edge.
REQ-013 idex_stall  output  1  load ID/EX with all-zero bubble next edge (drives the ID/EX stall input).
REQ-014 pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB unchanged.
REQ-015 state  output  2  FSM state: RUN=00, MEM_WAIT=01, FLUSH=10 (11 unused).
REQ-016 mem_timeout  output  1  sticky wait-timeout flag.
REQ-017 load_stall_cnt, flush_cnt, mem_wait_cnt  output  CNT_W each  performance counters.

Function
REQ-018 Load-use hazard lu = idex_Mem_Read && idex_rd!=0 && (idex_rd==ifid_rs1 || (ifid_uses_rs2 && idex_rd==ifid_rs2)).
REQ-019 All control outputs combinational from state and current inputs (same-cycle effect); state, wait counter, mem_timeout and counters registered.
REQ-020 Priority per cycle: memory freeze > branch flush > load-use stall > normal.
REQ-021 RUN, dmem_req && !dmem_ready: pipe_freeze=1, pc_write=0, ifid_write=0, no flush/bubble; next state MEM_WAIT, wait counter=1.
REQ-022 RUN, no freeze, branch_taken: ifid_flush=1, idex_stall=1, pc_write=1; next state FLUSH.
REQ-023 RUN, no freeze, no branch, lu: pc_write=0, ifid_write=0, idex_stall=1; stays RUN (bubble clears lu next cycle).
REQ-024 RUN otherwise: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-025 MEM_WAIT, !dmem_ready: freeze outputs as REQ-021; wait counter increments, saturating at 255; branch_taken and lu ignored.
REQ-026 Wait counter reaching MAX_WAIT sets mem_timeout, which holds until reset; FSM remains in MEM_WAIT.
REQ-027 MEM_WAIT, dmem_ready: freeze released this cycle; branch and lu evaluated as in RUN; next state FLUSH if branch_taken else RUN; wait counter cleared.
REQ-028 FLUSH: exactly one cycle; lu and branch_taken ignored (IF/ID holds bubble); freeze rule of REQ-021 still applies (next MEM_WAIT); else outputs as REQ-024, next RUN.
REQ-029 Counters: load_stall_cnt +1 per REQ-023 cycle; flush_cnt +1 per branch flush; mem_wait_cnt +1 per freeze cycle; each saturates at all-ones.

Reset
REQ-030 reset=1 at a clock edge: state=RUN, wait counter=0, mem_timeout=0, all counters=0, overriding any operation in progress, including MEM_WAIT.
REQ-031 While reset=1, outputs are driven as in RUN with inputs masked: pc_write=1, ifid_write=1, all other control outputs 0.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: the three counters implemented per REQ-029.
REQ-033 Macro undefined: counter ports remain present and are tied to 0; no counter flops; all other behaviour identical.

Verification
REQ-034 idex_Mem_Read=1, idex_rd=5, ifid_rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_stall=1; load_stall_cnt=1.
REQ-035 idex_rd=0 with ifid_rs1=0, or ifid_rs2=7 match with ifid_uses_rs2=0 -> no stall.
REQ-036 branch_taken=1 and lu=1 same cycle -> ifid_flush=1, idex_stall=1, pc_write=1; state=10 next cycle then 00; flush_cnt=1.
REQ-037 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 with branch_taken=1 -> freeze 3 cycles, flush on release cycle, mem_wait_cnt=3, state 01->10->00.
REQ-038 MAX_WAIT=4, dmem_ready held 0 -> mem_timeout=1 after 4th wait cycle, stays 1; reset mid-wait -> state=00, mem_timeout=0, counters 0.
